seq_match_fsm: RTL

Parametrised pattern-match counter and hit sequencer. It counts masked pattern matches over a valid burst, then replays one `hit` pulse per match with a programmable idle gap between pulses. It adds saturation, overflow and synchronous-abort handling, and it sits on the same stream-monitor path as the earlier fixed 4-bit count/assert FSM.

---
 rtl/seq_match_if.sv | 29 ++
 rtl/seq_match_fsm.sv | 115 +++++++++++
 2 files changed

// File: rtl/seq_match_if.sv
// Stream-monitor bus for seq_match_fsm: beat/compare inputs and match/hit status outputs.
interface seq_match_if #(
    parameter int DW = 8,
    parameter int CW = 4,
    parameter int GW = 3
) ();
    logic          valid;
    logic [DW-1:0] data;
    logic [DW-1:0] pattern;
    logic [DW-1:0] mask;
    logic [GW-1:0] gap;
    logic          ready;
    logic          busy;
    logic          hit;
    logic [CW-1:0] cnt;
    logic          ovf;

    // Stream source / configuration side
    modport master (
        output valid, data, pattern, mask, gap,
        input  ready, busy, hit, cnt, ovf
    );

    // Matcher side
    modport slave (
        input  valid, data, pattern, mask, gap,
        output ready, busy, hit, cnt, ovf
    );
endinterface

// File: rtl/seq_match_fsm.sv
// Counts masked pattern matches over a valid burst, then replays one hit pulse
// per counted match separated by a programmable number of idle cycles.
module seq_match_fsm #(
    parameter int DW = 8,
    parameter int CW = 4,
    parameter int GW = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    seq_match_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WATCH  = 2'd1,
        S_ASSERT = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [GW-1:0] gap_lat_q, gap_lat_d;
    logic          ovf_q, ovf_d;
    logic          match;

    // Saturating increment: the count sticks at its maximum instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    // Status outputs decode from the registered state only.
    assign bus.ready = (state_q == S_IDLE) || (state_q == S_WATCH);
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.hit   = (state_q == S_ASSERT);
    assign bus.cnt   = cnt_q;
    assign bus.ovf   = ovf_q;

    assign match = bus.valid && bus.ready &&
                   ((bus.data & bus.mask) == (bus.pattern & bus.mask));

    // Next-state, counter and sticky-overflow computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_cnt_d = gap_cnt_q;
        gap_lat_d = gap_lat_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.valid) begin
                    // Burst start: the overflow flag belongs to the previous burst.
                    state_d = S_WATCH;
                    ovf_d   = 1'b0;
                    if (match) begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            S_WATCH: begin
                if (bus.valid) begin
                    if (match) begin
                        cnt_d = sat_inc(cnt_q);
                        if (cnt_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end
                    end
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    // Freeze the gap for the whole replay of this burst.
                    state_d   = S_ASSERT;
                    gap_lat_d = bus.gap;
                end
            end
            S_ASSERT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                end else if (gap_lat_q != '0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = gap_lat_q;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - GW'(1);
                if (gap_cnt_q == GW'(1)) begin
                    state_d = S_ASSERT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers; reset and clear both abort any pending replay.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            gap_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ovf_q     <= ovf_d;
        end
        // Latched gap is always written on WATCH->ASSERT before it is used.
        gap_lat_q <= gap_lat_d;
    end

endmodule
